// File: rtl/vc_input_unit.sv
// vc_input_unit: multi-VC router input port.
//
// Splits one incoming link into NUM_VCS virtual channels. Each VC owns a flit
// FIFO, a latched route and downstream VC, and a per-packet pipeline state
// (IDLE -> ROUTING -> AWAITING_VC -> ACTIVE). Tail pops either retire the VC
// to IDLE or, when the next packet is already buffered, go straight back to
// ROUTING. Every honoured pop returns one credit upstream a cycle later.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_vc/in_flit      flit arriving from the link receiver
//   rc_req  (out)        per-VC request to route compute; head on head_flit
//   rc_valid/rc_vc/rc_route     route compute result
//   va_req  (out)        per-VC request to the VC allocator
//   va_valid/va_vc/va_out_vc    VC allocation grant
//   sa_pop               switch traversal pop (lowest set bit honoured)
//   active  (out)        VC is ACTIVE and holds a flit
//   head_flit (out)      FIFO head per VC, VC i at slice i (0 when empty)
//   route_out/vc_out (out)      latched route / downstream VC per VC
//   credits (out)        free slots per VC
//   credit_ret_valid/credit_ret_vc (out)  registered credit return
//   overflow (out)       sticky: a push to a full VC was dropped
//
// Optional feature, macro VC_INPUT_UNIT_PROTO_CHECK_EN: adds a sticky
// proto_err output flagging non-head flits at a packet boundary and head
// flits pushed behind an unterminated packet. Flit flow is unaffected.
module vc_input_unit #(
  parameter int  NUM_VCS    = 4,
  parameter int  DEPTH      = 8,
  parameter int  DATA_WIDTH = 64,
  localparam int VC_BITS    = $clog2(NUM_VCS),
  localparam int DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [VC_BITS-1:0]                in_vc,
  input  logic [DATA_WIDTH-1:0]             in_flit,
  output logic [NUM_VCS-1:0]                rc_req,
  input  logic                              rc_valid,
  input  logic [VC_BITS-1:0]                rc_vc,
  input  logic [2:0]                        rc_route,
  output logic [NUM_VCS-1:0]                va_req,
  input  logic                              va_valid,
  input  logic [VC_BITS-1:0]                va_vc,
  input  logic [VC_BITS-1:0]                va_out_vc,
  input  logic [NUM_VCS-1:0]                sa_pop,
  output logic [NUM_VCS-1:0]                active,
  output logic [NUM_VCS*DATA_WIDTH-1:0]     head_flit,
  output logic [NUM_VCS*3-1:0]              route_out,
  output logic [NUM_VCS*VC_BITS-1:0]        vc_out,
  output logic [NUM_VCS*(DEPTH_BITS+1)-1:0] credits,
  output logic                              credit_ret_valid,
  output logic [VC_BITS-1:0]                credit_ret_vc,
  output logic                              overflow
`ifdef VC_INPUT_UNIT_PROTO_CHECK_EN
  ,
  output logic                              proto_err
`endif
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ROUTING  = 2'd1;
  localparam logic [1:0] S_AWAIT_VC = 2'd2;
  localparam logic [1:0] S_ACTIVE   = 2'd3;

  localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem    [NUM_VCS][DEPTH];
  logic [DEPTH_BITS-1:0] r_rd_ptr [NUM_VCS];
  logic [DEPTH_BITS-1:0] r_wr_ptr [NUM_VCS];
  logic [DEPTH_BITS:0]   r_count  [NUM_VCS];
  logic [1:0]            r_state  [NUM_VCS];
  logic [2:0]            r_route  [NUM_VCS];
  logic [VC_BITS-1:0]    r_out_vc [NUM_VCS];
  logic                  r_cr_valid;
  logic [VC_BITS-1:0]    r_cr_vc;
  logic                  r_overflow;

  logic [DATA_WIDTH-1:0] w_head [NUM_VCS];
  logic [NUM_VCS-1:0]    w_nonempty;
  logic [NUM_VCS-1:0]    w_push_req;
  logic [NUM_VCS-1:0]    w_push;
  logic [NUM_VCS-1:0]    w_pop;
  logic                  w_sel_any;
  logic [VC_BITS-1:0]    w_sel_vc;
  logic                  w_ovf;

  // Lowest set bit of sa_pop is the only pop candidate; scanning downward
  // lets the lowest index overwrite higher ones.
  always_comb begin
    w_sel_any = 1'b0;
    w_sel_vc  = '0;
    for (int v = NUM_VCS - 1; v >= 0; v--) begin
      if (sa_pop[v]) begin
        w_sel_any = 1'b1;
        w_sel_vc  = VC_BITS'(v);
      end
    end
  end

  // A full FIFO still accepts a push when the same VC pops that cycle.
  always_comb begin
    w_ovf = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      w_nonempty[v] = (r_count[v] != '0);
      w_head[v]     = w_nonempty[v] ? r_mem[v][r_rd_ptr[v]] : '0;
      w_pop[v]      = w_sel_any && (w_sel_vc == VC_BITS'(v)) &&
                      (r_state[v] == S_ACTIVE) && w_nonempty[v];
      w_push_req[v] = in_valid && (in_vc == VC_BITS'(v));
      w_push[v]     = w_push_req[v] && ((r_count[v] != FULL_CNT) || w_pop[v]);
      if (w_push_req[v] && !w_push[v]) w_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (w_push[v]) r_mem[v][r_wr_ptr[v]] <= in_flit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        r_rd_ptr[v] <= '0;
        r_wr_ptr[v] <= '0;
        r_count[v]  <= '0;
        r_state[v]  <= S_IDLE;
        r_route[v]  <= '0;
        r_out_vc[v] <= '0;
      end
      r_cr_valid <= 1'b0;
      r_cr_vc    <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (w_push[v]) r_wr_ptr[v] <= r_wr_ptr[v] + DEPTH_BITS'(1);
        if (w_pop[v])  r_rd_ptr[v] <= r_rd_ptr[v] + DEPTH_BITS'(1);
        r_count[v] <= r_count[v] + (DEPTH_BITS+1)'(w_push[v])
                                 - (DEPTH_BITS+1)'(w_pop[v]);
        case (r_state[v])
          S_IDLE: begin
            // A same-cycle push counts, giving push N -> ROUTING N+1.
            if (w_nonempty[v] || w_push[v]) r_state[v] <= S_ROUTING;
          end
          S_ROUTING: begin
            if (rc_valid && (rc_vc == VC_BITS'(v))) begin
              r_route[v] <= rc_route;
              r_state[v] <= S_AWAIT_VC;
            end
          end
          S_AWAIT_VC: begin
            if (va_valid && (va_vc == VC_BITS'(v))) begin
              r_out_vc[v] <= va_out_vc;
              r_state[v]  <= S_ACTIVE;
            end
          end
          default: begin
            // Type MSB set means tail or head+tail: the packet ends here.
            if (w_pop[v] && w_head[v][DATA_WIDTH-1]) begin
              r_state[v] <= ((r_count[v] > (DEPTH_BITS+1)'(1)) || w_push[v])
                            ? S_ROUTING : S_IDLE;
            end
          end
        endcase
      end
      r_cr_valid <= |w_pop;
      if (|w_pop) r_cr_vc <= w_sel_vc;
      if (w_ovf) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      rc_req[v] = (r_state[v] == S_ROUTING);
      va_req[v] = (r_state[v] == S_AWAIT_VC);
      active[v] = (r_state[v] == S_ACTIVE) && w_nonempty[v];
      head_flit[v*DATA_WIDTH +: DATA_WIDTH]         = w_head[v];
      route_out[v*3 +: 3]                           = r_route[v];
      vc_out[v*VC_BITS +: VC_BITS]                  = r_out_vc[v];
      credits[v*(DEPTH_BITS+1) +: (DEPTH_BITS+1)]   = FULL_CNT - r_count[v];
    end
  end

  assign credit_ret_valid = r_cr_valid;
  assign credit_ret_vc    = r_cr_vc;
  assign overflow         = r_overflow;

`ifdef VC_INPUT_UNIT_PROTO_CHECK_EN
  logic r_proto_err;
  logic w_proto_hit;

  // Type bit DATA_WIDTH-2 marks a head; bit DATA_WIDTH-1 marks a tail.
  always_comb begin
    w_proto_hit = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (((r_state[v] == S_IDLE) || (r_state[v] == S_ROUTING)) &&
          w_nonempty[v] && !w_head[v][DATA_WIDTH-2]) begin
        w_proto_hit = 1'b1;
      end
      if (w_push_req[v] && in_flit[DATA_WIDTH-2] && w_nonempty[v] &&
          !r_mem[v][r_wr_ptr[v] - DEPTH_BITS'(1)][DATA_WIDTH-1]) begin
        w_proto_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_proto_err <= 1'b0;
    else if (w_proto_hit) r_proto_err <= 1'b1;
  end

  assign proto_err = r_proto_err;
`endif

endmodule

// File: tb/tb_vc_input_unit.sv
module tb_vc_input_unit;
  localparam int NV = 4;
  localparam int DP = 8;
  localparam int DW = 64;
  localparam int VB = 2;
  localparam int DB = 3;
  localparam int CW = NV * DW;

  localparam int M_IDLE = 0;
  localparam int M_RC   = 1;
  localparam int M_VA   = 2;
  localparam int M_ACT  = 3;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic [VB-1:0]       in_vc;
  logic [DW-1:0]       in_flit;
  logic [NV-1:0]       rc_req;
  logic                rc_valid;
  logic [VB-1:0]       rc_vc;
  logic [2:0]          rc_route;
  logic [NV-1:0]       va_req;
  logic                va_valid;
  logic [VB-1:0]       va_vc;
  logic [VB-1:0]       va_out_vc;
  logic [NV-1:0]       sa_pop;
  logic [NV-1:0]       active;
  logic [NV*DW-1:0]    head_flit;
  logic [NV*3-1:0]     route_out;
  logic [NV*VB-1:0]    vc_out;
  logic [NV*(DB+1)-1:0] credits;
  logic                credit_ret_valid;
  logic [VB-1:0]       credit_ret_vc;
  logic                overflow;
`ifdef VC_INPUT_UNIT_PROTO_CHECK_EN
  logic                proto_err;
`endif

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  vc_input_unit #(.NUM_VCS(NV), .DEPTH(DP), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
    .rc_req(rc_req), .rc_valid(rc_valid), .rc_vc(rc_vc), .rc_route(rc_route),
    .va_req(va_req), .va_valid(va_valid), .va_vc(va_vc), .va_out_vc(va_out_vc),
    .sa_pop(sa_pop), .active(active), .head_flit(head_flit),
    .route_out(route_out), .vc_out(vc_out), .credits(credits),
    .credit_ret_valid(credit_ret_valid), .credit_ret_vc(credit_ret_vc),
    .overflow(overflow)
`ifdef VC_INPUT_UNIT_PROTO_CHECK_EN
    , .proto_err(proto_err)
`endif
  );

  // Reference model: one queue of flits per VC plus packet phase bookkeeping.
  logic [DW-1:0] mq [NV][$];
  int            mst [NV];
  logic [2:0]    mroute [NV];
  logic [VB-1:0] mvc [NV];
  logic          mcrv;
  logic [VB-1:0] mcrvc;
  logic          movf;

  function automatic logic [DW-1:0] mkf(input logic [1:0] t, input int id);
    return {t, 30'h2A5A5, 32'(id)};
  endfunction

  function automatic logic [DB:0] cr(input int v);
    return credits[v*(DB+1) +: (DB+1)];
  endfunction
  function automatic logic [2:0] rt(input int v);
    return route_out[v*3 +: 3];
  endfunction
  function automatic logic [VB-1:0] vo(input int v);
    return vc_out[v*VB +: VB];
  endfunction
  function automatic logic [DW-1:0] hf(input int v);
    return head_flit[v*DW +: DW];
  endfunction

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      mq[v].delete();
      mst[v] = M_IDLE;
      mroute[v] = '0;
      mvc[v] = '0;
    end
    mcrv = 1'b0; mcrvc = '0; movf = 1'b0;
  endtask

  task automatic model_step();
    int lo, pv, n;
    bit pushok [NV];
    lo = -1;
    for (int v = NV - 1; v >= 0; v--) if (sa_pop[v]) lo = v;
    pv = -1;
    if (lo >= 0) if (mst[lo] == M_ACT && mq[lo].size() > 0) pv = lo;
    for (int v = 0; v < NV; v++) begin
      n = mq[v].size();
      pushok[v] = in_valid && (int'(in_vc) == v) && (n < DP || pv == v);
      if (in_valid && int'(in_vc) == v && !pushok[v]) movf = 1'b1;
      case (mst[v])
        M_IDLE: if (n > 0 || pushok[v]) mst[v] = M_RC;
        M_RC: if (rc_valid && int'(rc_vc) == v) begin mroute[v] = rc_route; mst[v] = M_VA; end
        M_VA: if (va_valid && int'(va_vc) == v) begin mvc[v] = va_out_vc; mst[v] = M_ACT; end
        default: if (pv == v && mq[v][0][DW-1]) mst[v] = (n > 1 || pushok[v]) ? M_RC : M_IDLE;
      endcase
      if (pv == v) void'(mq[v].pop_front());
      if (pushok[v]) mq[v].push_back(in_flit);
    end
    mcrv = (pv >= 0);
    if (pv >= 0) mcrvc = VB'(pv);
  endtask

  task automatic check_all();
    logic [NV-1:0] erc, eva, eact;
    logic [NV*DW-1:0] ehf;
    logic [NV*3-1:0] ert;
    logic [NV*VB-1:0] evc;
    logic [NV*(DB+1)-1:0] ecr;
    for (int v = 0; v < NV; v++) begin
      erc[v] = (mst[v] == M_RC);
      eva[v] = (mst[v] == M_VA);
      eact[v] = (mst[v] == M_ACT) && (mq[v].size() > 0);
      ehf[v*DW +: DW] = (mq[v].size() > 0) ? mq[v][0] : '0;
      ert[v*3 +: 3] = mroute[v];
      evc[v*VB +: VB] = mvc[v];
      ecr[v*(DB+1) +: (DB+1)] = (DB+1)'(DP - mq[v].size());
    end
    chk("rc_req", CW'(rc_req), CW'(erc));
    chk("va_req", CW'(va_req), CW'(eva));
    chk("active", CW'(active), CW'(eact));
    chk("head_flit", CW'(head_flit), CW'(ehf));
    chk("route_out", CW'(route_out), CW'(ert));
    chk("vc_out", CW'(vc_out), CW'(evc));
    chk("credits", CW'(credits), CW'(ecr));
    chk("credit_ret_valid", CW'(credit_ret_valid), CW'(mcrv));
    if (mcrv) chk("credit_ret_vc", CW'(credit_ret_vc), CW'(mcrvc));
    chk("overflow", CW'(overflow), CW'(movf));
  endtask

  task automatic clr_in();
    in_valid = 1'b0; in_vc = '0; in_flit = '0;
    rc_valid = 1'b0; rc_vc = '0; rc_route = '0;
    va_valid = 1'b0; va_vc = '0; va_out_vc = '0;
    sa_pop = '0;
  endtask

  task automatic push(input int v, input logic [DW-1:0] f);
    in_valid = 1'b1; in_vc = VB'(v); in_flit = f;
  endtask
  task automatic rc(input int v, input int r);
    rc_valid = 1'b1; rc_vc = VB'(v); rc_route = 3'(r);
  endtask
  task automatic va(input int v, input int o);
    va_valid = 1'b1; va_vc = VB'(v); va_out_vc = VB'(o);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    clr_in();
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();
  endtask

  typedef struct {
    logic pv; logic [1:0] pt; logic rcv; logic [2:0] rcr;
    logic vav; logic [VB-1:0] vaov; logic [NV-1:0] pop;
    logic [NV-1:0] e_rc; logic [NV-1:0] e_va; logic [NV-1:0] e_act;
    logic e_crv; logic [DB:0] e_cr2; logic [2:0] e_rt2; logic [VB-1:0] e_vc2;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [5];
    tv[0] = '{1'b1, T_HT, 1'b0, 3'd0, 1'b0, 2'd0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, 4'd7, 3'd0, 2'd0};
    tv[1] = '{1'b0, T_BODY, 1'b1, 3'd3, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 4'd7, 3'd3, 2'd0};
    tv[2] = '{1'b0, T_BODY, 1'b0, 3'd0, 1'b1, 2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0, 4'd7, 3'd3, 2'd1};
    tv[3] = '{1'b0, T_BODY, 1'b0, 3'd0, 1'b0, 2'd0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'd8, 3'd3, 2'd1};
    tv[4] = '{1'b0, T_BODY, 1'b0, 3'd0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'd8, 3'd3, 2'd1};

    // Reset state
    clr_in();
    reset = 1'b1;
    model_reset();
    #2;
    check_all();
    chk("rst_credits", CW'(credits), CW'({4{4'd8}}));
    chk("rst_head", CW'(head_flit), CW'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single head+tail flit on VC2, table-driven
    for (int i = 0; i < 5; i++) begin
      if (tv[i].pv) push(2, mkf(tv[i].pt, 42));
      if (tv[i].rcv) rc(2, int'(tv[i].rcr));
      if (tv[i].vav) va(2, int'(tv[i].vaov));
      sa_pop = tv[i].pop;
      tick();
      chk($sformatf("t%0d_rc_req", i), CW'(rc_req), CW'(tv[i].e_rc));
      chk($sformatf("t%0d_va_req", i), CW'(va_req), CW'(tv[i].e_va));
      chk($sformatf("t%0d_active", i), CW'(active), CW'(tv[i].e_act));
      chk($sformatf("t%0d_crv", i), CW'(credit_ret_valid), CW'(tv[i].e_crv));
      if (tv[i].e_crv) chk($sformatf("t%0d_crvc", i), CW'(credit_ret_vc), CW'(2));
      chk($sformatf("t%0d_cr2", i), CW'(cr(2)), CW'(tv[i].e_cr2));
      chk($sformatf("t%0d_rt2", i), CW'(rt(2)), CW'(tv[i].e_rt2));
      chk($sformatf("t%0d_vc2", i), CW'(vo(2)), CW'(tv[i].e_vc2));
    end

    // Fill VC0, push+pop while full, then overflow
    do_reset();
    for (int k = 0; k < 8; k++) begin
      push(0, mkf(k == 0 ? T_HEAD : T_BODY, 100 + k));
      if (k == 1) rc(0, 4);
      if (k == 2) va(0, 2);
      tick();
    end
    chk("full_cr0", CW'(cr(0)), CW'(0));
    chk("full_ovf", CW'(overflow), CW'(0));
    push(0, mkf(T_BODY, 108));
    sa_pop = 4'b0001;
    tick();
    chk("pushpop_ovf", CW'(overflow), CW'(0));
    chk("pushpop_cr0", CW'(cr(0)), CW'(0));
    chk("pushpop_head", CW'(hf(0)), CW'(mkf(T_BODY, 101)));
    push(0, mkf(T_BODY, 109));
    tick();
    chk("ovf_set", CW'(overflow), CW'(1));
    chk("ovf_cr0", CW'(cr(0)), CW'(0));
    chk("ovf_head", CW'(hf(0)), CW'(mkf(T_BODY, 101)));

    // Back-to-back 2-flit packets on VC1
    do_reset();
    push(1, mkf(T_HEAD, 200)); tick();
    push(1, mkf(T_TAIL, 201)); rc(1, 5); tick();
    push(1, mkf(T_HEAD, 202)); va(1, 2); tick();
    push(1, mkf(T_TAIL, 203)); sa_pop = 4'b0010; tick();
    sa_pop = 4'b0010; tick();
    chk("b2b_rc_req", CW'(rc_req[1]), CW'(1));
    chk("b2b_head", CW'(hf(1)), CW'(mkf(T_HEAD, 202)));
    chk("b2b_old_route", CW'(rt(1)), CW'(5));
    rc(1, 6); tick();
    chk("b2b_new_route", CW'(rt(1)), CW'(6));
    va(1, 3); tick();
    chk("b2b_vc", CW'(vo(1)), CW'(3));
    sa_pop = 4'b0010; tick();
    sa_pop = 4'b0010; tick();
    chk("b2b_idle", CW'({rc_req[1], va_req[1], active[1]}), CW'(0));
    chk("b2b_cr1", CW'(cr(1)), CW'(8));
    chk("b2b_crvc", CW'(credit_ret_vc), CW'(1));

    // Pop ignored while VC3 awaits a VC; stray rc/va ignored
    do_reset();
    push(3, mkf(T_HT, 300)); tick();
    rc(3, 7); tick();
    sa_pop = 4'b1000; rc(3, 2); va(0, 3); tick();
    chk("await_cr3", CW'(cr(3)), CW'(7));
    chk("await_crv", CW'(credit_ret_valid), CW'(0));
    chk("await_route", CW'(rt(3)), CW'(7));
    chk("await_va0", CW'(vo(0)), CW'(0));
    va(3, 1); tick();
    sa_pop = 4'b1000; tick();
    chk("await_done_crv", CW'(credit_ret_valid), CW'(1));

    // Interleaved VC0/VC3 with reversed grants
    do_reset();
    push(0, mkf(T_HEAD, 500)); tick();
    push(3, mkf(T_HEAD, 600)); rc(0, 1); tick();
    push(0, mkf(T_TAIL, 501)); rc(3, 2); tick();
    push(3, mkf(T_TAIL, 601)); va(3, 2); tick();
    va(0, 1); tick();
    chk("il_active", CW'(active), CW'(4'b1001));
    chk("il_vc0", CW'(vo(0)), CW'(1));
    chk("il_vc3", CW'(vo(3)), CW'(2));
    sa_pop = 4'b1000; tick();
    chk("il_head3", CW'(hf(3)), CW'(mkf(T_TAIL, 601)));
    sa_pop = 4'b0001; tick();
    chk("il_head0", CW'(hf(0)), CW'(mkf(T_TAIL, 501)));
    sa_pop = 4'b1000; tick();
    sa_pop = 4'b0001; tick();
    chk("il_idle", CW'(active), CW'(0));

    // Asynchronous reset with VC1 active and holding three flits
    do_reset();
    push(1, mkf(T_HEAD, 700)); tick();
    push(1, mkf(T_BODY, 701)); rc(1, 2); tick();
    push(1, mkf(T_BODY, 702)); va(1, 1); tick();
    chk("pre_rst_active", CW'(active[1]), CW'(1));
    chk("pre_rst_cr1", CW'(cr(1)), CW'(5));
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async_cr", CW'(credits), CW'({4{4'd8}}));
    chk("async_outs", CW'({active, rc_req, va_req, route_out, vc_out, credit_ret_valid, overflow}), CW'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    chk("post_rst_cr1", CW'(cr(1)), CW'(8));

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset();
      if ($urandom_range(2) != 0) push(int'($urandom_range(NV - 1)), mkf(2'($urandom), i));
      if ($urandom_range(1) != 0) rc(int'($urandom_range(NV - 1)), int'($urandom_range(7)));
      if ($urandom_range(1) != 0) va(int'($urandom_range(NV - 1)), int'($urandom_range(NV - 1)));
      case ($urandom_range(9))
        0, 1, 2, 3, 4, 5: sa_pop = NV'(1) << $urandom_range(NV - 1);
        6: sa_pop = NV'($urandom);
        default: sa_pop = '0;
      endcase
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/vc_input_unit.md
Name: vc_input_unit

Overview:
- Multi-VC router input port. Generalises the single virtual-channel buffer to NUM_VCS independent channels behind one link.
- Each VC has its own flit FIFO, per-packet route/output-VC registers and a pipeline state machine (IDLE -> ROUTING -> AWAITING_VC -> ACTIVE).
- Adds tail-flit decode, back-to-back packet handling (ACTIVE -> ROUTING directly), per-VC credit counts and upstream credit return.
- Sits between the link receiver and the route-compute, VC-allocator and switch-allocator stages.

Parameters:
- NUM_VCS, 4, virtual channels per port (>=2)
- DEPTH, 8, flits per VC FIFO (power of two, >=2)
- DATA_WIDTH, 64, flit width; bits [DATA_WIDTH-1:DATA_WIDTH-2] are the type: 00 body, 01 head, 10 tail, 11 head+tail
- VC_BITS, $clog2(NUM_VCS), internal
- DEPTH_BITS, $clog2(DEPTH), internal

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  flit arriving this cycle
- in_vc  in  VC_BITS  target VC of arriving flit
- in_flit  in  DATA_WIDTH  arriving flit
- rc_req  out  NUM_VCS  VC is in ROUTING; its head flit is on head_flit
- rc_valid  in  1  route result valid
- rc_vc  in  VC_BITS  VC the route result is for
- rc_route  in  3  output port
- va_req  out  NUM_VCS  VC is in AWAITING_VC
- va_valid  in  1  VC allocation grant
- va_vc  in  VC_BITS  input VC granted
- va_out_vc  in  VC_BITS  downstream VC assigned
- sa_pop  in  NUM_VCS  switch traversal pop, at most one bit set
- active  out  NUM_VCS  VC in ACTIVE and non-empty
- head_flit  out  NUM_VCS*DATA_WIDTH  FIFO head per VC, VC i at slice i
- route_out  out  NUM_VCS*3  latched route per VC
- vc_out  out  NUM_VCS*VC_BITS  latched downstream VC per VC
- credits  out  NUM_VCS*(DEPTH_BITS+1)  free slots per VC
- credit_ret_valid  out  1  one flit freed upstream-visible
- credit_ret_vc  out  VC_BITS  VC whose slot was freed
- overflow  out  1  sticky: push to full VC dropped

Behaviour:
- Reset values:
  - All FIFOs empty; all states IDLE.
  - credits = DEPTH for every VC.
  - route_out, vc_out, active, rc_req, va_req, credit_ret_valid, credit_ret_vc, overflow all 0.
  - head_flit = 0.
- Reset mid-packet discards all buffered flits immediately (asynchronous).
- FIFO behaviour:
  - Push writes in_flit to VC in_vc when in_valid is high.
  - The flit is visible on head_flit (if FIFO was empty) and reflected in credits the next cycle.
  - Push to a full VC is dropped and sets overflow; no other state changes.
- Pop:
  - Only honoured when the VC is ACTIVE and non-empty. Any other sa_pop bit is ignored.
  - Multi-hot sa_pop: only the lowest set bit is honoured.
  - Simultaneous push and pop on the same VC is legal, including when full (count unchanged, no overflow) and when empty-but-pushing (pop ignored).
- Credit return:
  - Each honoured pop drives credit_ret_valid=1 and credit_ret_vc=VC, registered, one cycle after the pop.
- State machine, per VC:
  - IDLE: go to ROUTING when the FIFO is non-empty. Head-type checking is only done under the optional feature.
  - ROUTING: rc_req[i]=1. On rc_valid with rc_vc==i, latch rc_route into route_out slice i and go to AWAITING_VC.
  - AWAITING_VC: va_req[i]=1. On va_valid with va_vc==i, latch va_out_vc and go to ACTIVE.
  - ACTIVE: active[i] = non-empty. On an honoured pop of a tail or head+tail flit:
    - go to ROUTING if another flit remains (count>1, or a same-cycle push to this VC);
    - otherwise go to IDLE.
- Minimum head latency, push to first honoured pop: push N, ROUTING N+1, rc N+1, AWAITING N+2, va N+2, ACTIVE N+3, pop N+3.
- rc/va results for a VC not in the matching state are ignored.

Optional Feature:
- Macro VC_INPUT_UNIT_PROTO_CHECK_EN.
- Defined:
  - adds output proto_err (1 bit, sticky, reset 0);
  - sets proto_err when a VC in IDLE/ROUTING sees a non-head head flit, or a head flit is pushed to a VC whose newest buffered flit was not a tail;
  - flit flow is unaffected.
- Undefined: no proto_err port, no checking logic.

Test Plan:
- Single head+tail flit pushed to VC2 at cycle 0, rc_route=3 at cycle 1, va_out_vc=1 at cycle 2, sa_pop[2] at cycle 3 -> route_out[2]=3, vc_out[2]=1, active[2]=1 at cycle 3; credit_ret_valid=1 with credit_ret_vc=2 at cycle 4; state returns to IDLE; credits[2]=8.
- Fill VC0 with 8 flits, push a 9th -> overflow=1, credits[0]=0, head unchanged; push+pop in same cycle when full -> overflow not set again by that push, credits stays 0.
- Two back-to-back 2-flit packets on VC1 -> after tail pop, VC1 enters ROUTING next cycle (not IDLE); second route latched independently.
- sa_pop[3] asserted while VC3 is in AWAITING_VC -> no pop, credits[3] unchanged, no credit_ret.
- Interleaved pushes to VC0 and VC3 with va grants in reverse order -> each VC reaches ACTIVE with its own vc_out; data order per VC preserved.
- Assert reset while VC1 is ACTIVE holding 3 flits -> all outputs at reset values in the same cycle; credits[1]=8 after release.
